// File: rtl/io_serdes_pkg.sv
// io_serdes_pkg
// Shared definitions for the half-duplex pad serializer/deserializer:
// TX/RX state encodings, the default payload width and the counter-width helper.
package io_serdes_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2
    } tx_state_e;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

    // Bit counter width for a WIDTH-bit frame (never narrower than 1).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/io_serdes_shreg.sv
// io_serdes_shreg
// WIDTH-bit right-shifting register with parallel load and a bit counter.
// Shifting moves data toward bit 0 and inserts shift_in at the MSB, so the
// LSB leaves first and LSB-first serial input lands in the right place after
// WIDTH shifts. The counter restarts on load and stops at WIDTH-1.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   load_en      load load_data and clear the counter (wins over shift)
//   shift_en     shift one position, shift_in enters at the MSB
//   cnt_en       advance the bit counter (saturates at WIDTH-1)
//   data_o       current register contents
//   last_o       counter is at WIDTH-1
module io_serdes_shreg
    import io_serdes_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             shift_in,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign data_o = data_q;
    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_en) begin
            data_d = load_data;
            cnt_d  = '0;
        end else begin
            if (shift_en) begin
                data_d = {shift_in, data_q[WIDTH-1:1]};
            end
            if (cnt_en && !last_o) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/io_serdes.sv
// io_serdes
// Half-duplex serializer/deserializer for a bidirectional pad cell.
// Frame: start bit (1) followed by WIDTH data bits, LSB first.
// Ports:
//   IOCLK               sole clock (rising edge)
//   RSTN                synchronous active-low reset
//   TX_DATA/TX_VALID    word to send; accepted when TX_READY is also 1
//   TX_READY            transmitter can take a word at this edge
//   OUT, TS             registered pad data and drive enable (1 = drive)
//   IN                  serial data from the pad
//   RX_EN               receiver enable
//   RX_DATA/RX_VALID    last received word and its one-cycle update strobe
module io_serdes #(
    parameter int WIDTH = io_serdes_pkg::WIDTH_DEFAULT
) (
    input  logic             IOCLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic             OUT,
    output logic             TS,
    input  logic             IN,
    input  logic             RX_EN,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID
);

    // ---------------------------------------------------------------- TX
    io_serdes_pkg::tx_state_e tx_state_q, tx_state_d;
    logic             out_q, out_d;
    logic             ts_q, ts_d;
    logic             tx_load, tx_shift, tx_cnt_en;
    logic             tx_last, tx_ready, tx_xfer;
    logic [WIDTH-1:0] tx_word;

    io_serdes_shreg #(.WIDTH(WIDTH)) u_tx_sh (
        .clk       (IOCLK),
        .rst_n     (RSTN),
        .load_en   (tx_load),
        .load_data (TX_DATA),
        .shift_en  (tx_shift),
        .shift_in  (1'b0),
        .cnt_en    (tx_cnt_en),
        .data_o    (tx_word),
        .last_o    (tx_last)
    );

    // Ready also during the final data bit so frames can run back to back.
    assign tx_ready = (tx_state_q == io_serdes_pkg::TX_IDLE) ||
                      ((tx_state_q == io_serdes_pkg::TX_DATA) && tx_last);
    assign tx_xfer  = TX_VALID && tx_ready;

    // OUT/TS are computed one cycle ahead and registered. The word is shifted
    // as each bit is issued, so tx_word[0] is always the next bit to send; the
    // counter tracks the bit currently on the line.
    always_comb begin
        tx_state_d = tx_state_q;
        out_d      = 1'b0;
        ts_d       = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        tx_cnt_en  = 1'b0;
        case (tx_state_q)
            io_serdes_pkg::TX_IDLE: begin
                if (tx_xfer) begin
                    tx_state_d = io_serdes_pkg::TX_START;
                    tx_load    = 1'b1;
                    out_d      = 1'b1;
                    ts_d       = 1'b1;
                end
            end
            io_serdes_pkg::TX_START: begin
                tx_state_d = io_serdes_pkg::TX_DATA;
                tx_shift   = 1'b1;
                out_d      = tx_word[0];
                ts_d       = 1'b1;
            end
            io_serdes_pkg::TX_DATA: begin
                if (!tx_last) begin
                    tx_shift  = 1'b1;
                    tx_cnt_en = 1'b1;
                    out_d     = tx_word[0];
                    ts_d      = 1'b1;
                end else if (tx_xfer) begin
                    tx_state_d = io_serdes_pkg::TX_START;
                    tx_load    = 1'b1;
                    out_d      = 1'b1;
                    ts_d       = 1'b1;
                end else begin
                    tx_state_d = io_serdes_pkg::TX_IDLE;
                end
            end
            default: tx_state_d = io_serdes_pkg::TX_IDLE;
        endcase
    end

    always_ff @(posedge IOCLK) begin
        if (!RSTN) begin
            tx_state_q <= io_serdes_pkg::TX_IDLE;
            out_q      <= 1'b0;
            ts_q       <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            out_q      <= out_d;
            ts_q       <= ts_d;
        end
    end

    assign TX_READY = tx_ready;
    assign OUT      = out_q;
    assign TS       = ts_q;

    // ---------------------------------------------------------------- RX
    io_serdes_pkg::rx_state_e rx_state_q, rx_state_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_load, rx_shift, rx_last, rx_abort;
    logic [WIDTH-1:0] rx_word;

    io_serdes_shreg #(.WIDTH(WIDTH)) u_rx_sh (
        .clk       (IOCLK),
        .rst_n     (RSTN),
        .load_en   (rx_load),
        .load_data ({WIDTH{1'b0}}),
        .shift_en  (rx_shift),
        .shift_in  (IN),
        .cnt_en    (rx_shift),
        .data_o    (rx_word),
        .last_o    (rx_last)
    );

    // Our own drive on the line kills any receive in progress.
    assign rx_abort = !RX_EN || ts_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_load    = 1'b0;
        rx_shift   = 1'b0;
        case (rx_state_q)
            io_serdes_pkg::RX_IDLE: begin
                if (!rx_abort && IN) begin
                    rx_state_d = io_serdes_pkg::RX_SHIFT;
                    rx_load    = 1'b1;
                end
            end
            io_serdes_pkg::RX_SHIFT: begin
                if (rx_abort) begin
                    rx_state_d = io_serdes_pkg::RX_IDLE;
                    rx_load    = 1'b1;
                end else begin
                    rx_shift = 1'b1;
                    if (rx_last) begin
                        // Final bit goes straight into the output word.
                        rx_data_d  = {IN, rx_word[WIDTH-1:1]};
                        rx_valid_d = 1'b1;
                        rx_state_d = io_serdes_pkg::RX_IDLE;
                    end
                end
            end
            default: rx_state_d = io_serdes_pkg::RX_IDLE;
        endcase
    end

    always_ff @(posedge IOCLK) begin
        if (!RSTN) begin
            rx_state_q <= io_serdes_pkg::RX_IDLE;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;

    // TX only ever reads the LSB; RX completes its word from bits above the LSB.
    logic shreg_unused;
    assign shreg_unused = ^{rx_word[0], tx_word[WIDTH-1:1]};

endmodule

// File: tb/tb_io_serdes.sv
module tb_io_serdes;

    localparam int W = 8;

    logic         IOCLK = 1'b0;
    logic         RSTN = 1'b0;
    logic [W-1:0] TX_DATA = '0;
    logic         TX_VALID = 1'b0;
    logic         TX_READY;
    logic         OUT;
    logic         TS;
    logic         IN = 1'b0;
    logic         RX_EN = 1'b0;
    logic [W-1:0] RX_DATA;
    logic         RX_VALID;

    int checks = 0;
    int errors = 0;

    io_serdes #(.WIDTH(W)) dut (
        .IOCLK    (IOCLK),
        .RSTN     (RSTN),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .OUT      (OUT),
        .TS       (TS),
        .IN       (IN),
        .RX_EN    (RX_EN),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID)
    );

    always #5 IOCLK = ~IOCLK;

    // Reference model: the line is a queue of bits still to be driven; the
    // receiver collects samples into a queue until a full word is present.
    bit           txq[$];
    bit           rxq[$];
    logic         m_ts = 1'b0, m_out = 1'b0, m_rdy = 1'b1, m_rxv = 1'b0;
    logic [W-1:0] m_rxd = '0;
    bit           m_busy = 1'b0;
    int           m_xfers = 0;

    always @(posedge IOCLK) begin : model
        bit           ts_now;
        logic [W-1:0] w;
        if (!RSTN) begin
            txq.delete();
            rxq.delete();
            m_ts = 1'b0; m_out = 1'b0; m_rxv = 1'b0; m_rxd = '0; m_busy = 1'b0;
        end else begin
            ts_now = m_ts;
            if (TX_VALID && txq.size() == 0) begin
                txq.push_back(1'b1);
                for (int i = 0; i < W; i++) txq.push_back(TX_DATA[i]);
                m_xfers++;
            end
            if (txq.size() > 0) begin
                m_ts  = 1'b1;
                m_out = txq.pop_front();
            end else begin
                m_ts  = 1'b0;
                m_out = 1'b0;
            end
            m_rxv = 1'b0;
            if (!RX_EN || ts_now) begin
                m_busy = 1'b0;
                rxq.delete();
            end else if (!m_busy) begin
                if (IN) m_busy = 1'b1;
            end else begin
                rxq.push_back(IN);
                if (rxq.size() == W) begin
                    for (int i = 0; i < W; i++) w[i] = rxq[i];
                    m_rxd  = w;
                    m_rxv  = 1'b1;
                    m_busy = 1'b0;
                    rxq.delete();
                end
            end
        end
        m_rdy = (txq.size() == 0);
    end

    task automatic test_reset();
        RSTN = 1'b0; TX_VALID = 1'b0; TX_DATA = '0; RX_EN = 1'b0; IN = 1'b0;
        repeat (3) @(negedge IOCLK);
        checks++;
        if ({TS, OUT, RX_VALID} !== 3'b000) begin
            errors++; $display("FAIL reset_outs got %b exp 000", {TS, OUT, RX_VALID});
        end
        checks++;
        if (RX_DATA !== '0) begin
            errors++; $display("FAIL reset_rxdata got %h exp 00", RX_DATA);
        end
        checks++;
        if (TX_READY !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", TX_READY);
        end
        RSTN = 1'b1;
    endtask

    task automatic test_tx_frame();
        logic [63:0] bits = '0;
        int nts = 0;
        @(negedge IOCLK);
        TX_DATA = 8'hA5; TX_VALID = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge IOCLK);
            TX_VALID = 1'b0;
            checks++;
            if ({TS, OUT, TX_READY, RX_VALID, RX_DATA} !== {m_ts, m_out, m_rdy, m_rxv, m_rxd}) begin
                errors++; $display("FAIL tx_frame_cyc%0d got %h exp %h", c,
                    {TS, OUT, TX_READY, RX_VALID, RX_DATA}, {m_ts, m_out, m_rdy, m_rxv, m_rxd});
            end
            if (TS === 1'b1 && nts < 64) begin bits[nts] = OUT; nts++; end
        end
        checks++;
        if (nts != 9) begin errors++; $display("FAIL tx_frame_len got %0d exp 9", nts); end
        checks++;
        if (bits[8:0] !== {8'hA5, 1'b1}) begin
            errors++; $display("FAIL tx_frame_bits got %b exp %b", bits[8:0], {8'hA5, 1'b1});
        end
        checks++;
        if ({TS, OUT} !== 2'b00) begin errors++; $display("FAIL tx_frame_idle got %b exp 00", {TS, OUT}); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] bits = '0;
        int nts = 0, rises = 0, x0;
        logic prev = 1'b0;
        @(negedge IOCLK);
        x0 = m_xfers;
        TX_DATA = 8'h01; TX_VALID = 1'b1;
        for (int c = 0; c < 26; c++) begin
            @(negedge IOCLK);
            if (m_xfers - x0 == 1) TX_DATA = 8'h80;
            if (m_xfers - x0 >= 2) TX_VALID = 1'b0;
            checks++;
            if ({TS, OUT, TX_READY, RX_VALID, RX_DATA} !== {m_ts, m_out, m_rdy, m_rxv, m_rxd}) begin
                errors++; $display("FAIL b2b_cyc%0d got %h exp %h", c,
                    {TS, OUT, TX_READY, RX_VALID, RX_DATA}, {m_ts, m_out, m_rdy, m_rxv, m_rxd});
            end
            if (TS === 1'b1 && !prev) rises++;
            prev = (TS === 1'b1);
            if (TS === 1'b1 && nts < 64) begin bits[nts] = OUT; nts++; end
        end
        TX_VALID = 1'b0;
        checks++;
        if (nts != 18) begin errors++; $display("FAIL b2b_len got %0d exp 18", nts); end
        checks++;
        if (rises != 1) begin errors++; $display("FAIL b2b_gap got %0d bursts exp 1", rises); end
        checks++;
        if (bits[17:0] !== {8'h80, 1'b1, 8'h01, 1'b1}) begin
            errors++; $display("FAIL b2b_bits got %b exp %b", bits[17:0], {8'h80, 1'b1, 8'h01, 1'b1});
        end
    endtask

    task automatic test_rx_frame();
        logic [8:0] seq = 9'b001111001;  // IN per cycle, index 0 first
        int pulses = 0, at = -1;
        @(negedge IOCLK);
        RX_EN = 1'b1; IN = seq[0];
        for (int i = 1; i < 9; i++) begin
            @(negedge IOCLK);
            checks++;
            if ({TS, OUT, TX_READY, RX_VALID, RX_DATA} !== {m_ts, m_out, m_rdy, m_rxv, m_rxd}) begin
                errors++; $display("FAIL rx_frame_bit%0d got %h exp %h", i,
                    {TS, OUT, TX_READY, RX_VALID, RX_DATA}, {m_ts, m_out, m_rdy, m_rxv, m_rxd});
            end
            IN = seq[i];
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge IOCLK);
            IN = 1'b0;
            checks++;
            if ({TS, OUT, TX_READY, RX_VALID, RX_DATA} !== {m_ts, m_out, m_rdy, m_rxv, m_rxd}) begin
                errors++; $display("FAIL rx_frame_tail%0d got %h exp %h", c,
                    {TS, OUT, TX_READY, RX_VALID, RX_DATA}, {m_ts, m_out, m_rdy, m_rxv, m_rxd});
            end
            if (RX_VALID === 1'b1) begin pulses++; if (at < 0) at = c; end
        end
        checks++;
        if (pulses != 1 || at != 0) begin
            errors++; $display("FAIL rx_valid_pulse got %0d pulses at %0d exp 1 at 0", pulses, at);
        end
        checks++;
        if (RX_DATA !== 8'h3C) begin errors++; $display("FAIL rx_data got %h exp 3c", RX_DATA); end
    endtask

    task automatic test_rx_abort_en();
        int pulses = 0;
        @(negedge IOCLK);
        RX_EN = 1'b1; IN = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge IOCLK);
            IN = 1'($urandom);
            if (c >= 4) RX_EN = 1'b0;
            checks++;
            if ({TS, OUT, TX_READY, RX_VALID, RX_DATA} !== {m_ts, m_out, m_rdy, m_rxv, m_rxd}) begin
                errors++; $display("FAIL rx_abort_en_cyc%0d got %h exp %h", c,
                    {TS, OUT, TX_READY, RX_VALID, RX_DATA}, {m_ts, m_out, m_rdy, m_rxv, m_rxd});
            end
            if (RX_VALID === 1'b1) pulses++;
        end
        IN = 1'b0;
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL rx_abort_en_valid got %0d exp 0", pulses); end
        checks++;
        if (RX_DATA !== 8'h3C) begin errors++; $display("FAIL rx_abort_en_hold got %h exp 3c", RX_DATA); end
    endtask

    task automatic test_rx_abort_tx();
        logic [63:0] bits = '0;
        logic [W-1:0] d = W'($urandom);
        int nts = 0, pulses = 0;
        @(negedge IOCLK);
        RX_EN = 1'b1; IN = 1'b1;
        repeat (3) begin
            @(negedge IOCLK);
            IN = 1'($urandom);
        end
        TX_DATA = d; TX_VALID = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge IOCLK);
            TX_VALID = 1'b0;
            IN = (c < 8) ? 1'($urandom) : 1'b0;
            checks++;
            if ({TS, OUT, TX_READY, RX_VALID, RX_DATA} !== {m_ts, m_out, m_rdy, m_rxv, m_rxd}) begin
                errors++; $display("FAIL rx_abort_tx_cyc%0d got %h exp %h", c,
                    {TS, OUT, TX_READY, RX_VALID, RX_DATA}, {m_ts, m_out, m_rdy, m_rxv, m_rxd});
            end
            if (RX_VALID === 1'b1) pulses++;
            if (TS === 1'b1 && nts < 64) begin bits[nts] = OUT; nts++; end
        end
        RX_EN = 1'b0;
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL rx_abort_tx_valid got %0d exp 0", pulses); end
        checks++;
        if (nts != 9 || bits[8:0] !== {d, 1'b1}) begin
            errors++; $display("FAIL rx_abort_tx_frame got %0d:%b exp 9:%b", nts, bits[8:0], {d, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] bits = '0;
        int nts = 0;
        @(negedge IOCLK);
        TX_DATA = 8'hC3; TX_VALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge IOCLK);
            TX_VALID = 1'b0;
        end
        RSTN = 1'b0;  // line is carrying data bit 3 now
        @(negedge IOCLK);
        checks++;
        if ({TS, OUT} !== 2'b00) begin errors++; $display("FAIL rst_mid_line got %b exp 00", {TS, OUT}); end
        checks++;
        if (RX_DATA !== '0) begin errors++; $display("FAIL rst_mid_rxdata got %h exp 00", RX_DATA); end
        RSTN = 1'b1;
        @(negedge IOCLK);
        checks++;
        if (TX_READY !== 1'b1 || TS !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ready got %b%b exp 10", TX_READY, TS);
        end
        TX_DATA = 8'h5A; TX_VALID = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge IOCLK);
            TX_VALID = 1'b0;
            checks++;
            if ({TS, OUT, TX_READY, RX_VALID, RX_DATA} !== {m_ts, m_out, m_rdy, m_rxv, m_rxd}) begin
                errors++; $display("FAIL rst_mid_cyc%0d got %h exp %h", c,
                    {TS, OUT, TX_READY, RX_VALID, RX_DATA}, {m_ts, m_out, m_rdy, m_rxv, m_rxd});
            end
            if (TS === 1'b1 && nts < 64) begin bits[nts] = OUT; nts++; end
        end
        checks++;
        if (nts != 9 || bits[8:0] !== {8'h5A, 1'b1}) begin
            errors++; $display("FAIL rst_mid_frame got %0d:%b exp 9:%b", nts, bits[8:0], {8'h5A, 1'b1});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            @(negedge IOCLK);
            checks++;
            if ({TS, OUT, TX_READY, RX_VALID, RX_DATA} !== {m_ts, m_out, m_rdy, m_rxv, m_rxd}) begin
                errors++; $display("FAIL random_cyc%0d got %h exp %h", c,
                    {TS, OUT, TX_READY, RX_VALID, RX_DATA}, {m_ts, m_out, m_rdy, m_rxv, m_rxd});
            end
            TX_VALID = ($urandom_range(0, 5) == 0);
            TX_DATA  = W'($urandom);
            RX_EN    = ($urandom_range(0, 15) != 0);
            IN       = 1'($urandom);
        end
        TX_VALID = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_rx_frame();
        test_rx_abort_en();
        test_rx_abort_tx();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_serdes.md
IO_SERDES -- requirements
Module: io_serdes

Interface
REQ-001 Parameter WIDTH, default 8, number of payload bits per frame (legal range 2..32).
REQ-002 IOCLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RSTN  input  1  reset, synchronous and active-low.
REQ-004 TX_DATA  input  WIDTH  word to serialize.
REQ-005 TX_VALID  input  1  TX_DATA is valid.
REQ-006 TX_READY  output  1  block accepts TX_DATA at this edge.
REQ-007 OUT  output  1  serial data toward the pad cell OUT input.
REQ-008 TS  output  1  pad drive enable toward the pad cell TS input (1 = drive, 0 = high-Z).
REQ-009 IN  input  1  serial data from the pad cell IN output; the block does not depend on whether the pad cell registers it.
REQ-010 RX_EN  input  1  receiver enable.
REQ-011 RX_DATA  output  WIDTH  last completely received word.
REQ-012 RX_VALID  output  1  one-cycle strobe: RX_DATA updated.

Function
REQ-013 Frame format: one start bit (1), then WIDTH data bits LSB first; the line is half-duplex.
REQ-014 TX FSM states: TX_IDLE, TX_START, TX_DATA.
REQ-015 TX_READY SHALL be 1 in TX_IDLE, and in TX_DATA when bit index = WIDTH-1; it SHALL be 0 otherwise.
REQ-016 A transfer occurs at an edge where TX_VALID=1 and TX_READY=1; TX_DATA is captured into the TX shift register.
REQ-017 After a transfer at edge k: TX_START during cycle k+1 (OUT=1, TS=1); TX_DATA bit i during cycle k+2+i for i = 0..WIDTH-1.
REQ-018 A transfer during the last data bit SHALL go directly to TX_START with no idle gap (back-to-back frames).
REQ-019 After the last bit with no new transfer, the FSM SHALL return to TX_IDLE with TS=0 and OUT=0.
REQ-020 OUT and TS SHALL be registered outputs with no combinational path from the inputs.
REQ-021 TX_DATA/TX_VALID changes while TX_READY=0 SHALL be ignored.
REQ-022 RX FSM states: RX_IDLE, RX_SHIFT.
REQ-023 In RX_IDLE with RX_EN=1 and TS=0, IN=1 sampled at an edge SHALL enter RX_SHIFT.
REQ-024 The next WIDTH edges in RX_SHIFT SHALL sample IN into data bits 0..WIDTH-1 (LSB first).
REQ-025 At the edge that samples bit WIDTH-1: the word loads into RX_DATA, RX_VALID=1 for exactly the following cycle, and the FSM returns to RX_IDLE.
REQ-026 RX_DATA SHALL hold its value until the next completed frame.
REQ-027 RX_EN=0 at any edge SHALL abort RX to RX_IDLE, discard partial bits, and emit no RX_VALID.
REQ-028 TX has priority: TS=1 at any edge SHALL abort an RX frame in progress exactly as in REQ-027, so the receiver never captures its own transmission.
REQ-029 Bit counters SHALL count 0..WIDTH-1 with no wrap beyond WIDTH-1; counter width is clog2(WIDTH).

Reset
REQ-030 RSTN=0 at an edge SHALL force TX_IDLE and RX_IDLE, TS=0, OUT=0, RX_VALID=0, RX_DATA=0, and counters and shift registers to 0.
REQ-031 Reset asserted mid-frame SHALL abandon both frames with no partial output; TX_READY=1 in the first cycle after release.

Structure
REQ-032 Package io_serdes_pkg SHALL hold the TX/RX state enums and the WIDTH default constant.
REQ-033 One sub-module, io_serdes_shreg, SHALL implement a WIDTH-bit shift register with load, shift-in and bit counter, instantiated once for TX and once for RX.

Verification (WIDTH=8)
REQ-034 TX_DATA=0xA5 with TX_VALID held 1 cycle -> TS=1 for 9 cycles; OUT=1,1,0,1,0,0,1,0,1; then TS=0.
REQ-035 Two words 0x01 then 0x80 with TX_VALID held -> 18 consecutive TS=1 cycles; second start bit immediately follows bit 7 of 0x01.
REQ-036 RX_EN=1, IN=1 then 0,0,1,1,1,1,0,0 -> RX_VALID for one cycle after the 8th data sample; RX_DATA=0x3C.
REQ-037 RX_EN dropped after 4 data bits -> no RX_VALID; RX_DATA keeps its previous value 0x3C.
REQ-038 RX mid-frame when a TX transfer occurs -> RX aborts with no RX_VALID; TX frame is output intact.
REQ-039 RSTN=0 during TX bit 3 -> next cycle TS=0, OUT=0; TX_READY=1 after release; a new 0x5A frame is sent correctly.
